// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with two display pages
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module disp_scan_ctrl #(
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned BLANK_CYC   = 50,
    parameter int unsigned PAGE_FRAMES = 250
) (
    input  logic        clkIn,
    input  logic        rst_n,
    input  logic [31:0] in,
    input  logic [1:0]  page_mode,
    input  logic        hold,
    output logic [7:0]  led,
    output logic [3:0]  sele,
    output logic        page,
    output logic        frame_tick
);

    localparam int unsigned CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [15:0]   FCNT_LAST = 16'(PAGE_FRAMES - 1);

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          page_q, page_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    led_q, led_d;
    logic [3:0]    sele_q, sele_d;
    logic          tick_q, tick_d;

    logic          frame_start;
    phase_e        phase;
    logic [15:0]   page_word;
    logic [3:0]    nib;
    logic          dp_n;
    logic          lz_blank;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot/digit sequencing plus the once-per-frame snapshot and page update.
    always_comb begin
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        fcnt_d      = fcnt_q;
        page_d      = page_q;
        shadow_d    = shadow_q;
        tick_d      = 1'b0;
        frame_start = (cnt_q == '0) && (dig_q == 2'd0);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (frame_start) begin
            tick_d = 1'b1;
            if (!hold) begin
                shadow_d = in;
            end
            case (page_mode)
                2'b01:   page_d = 1'b0;
                2'b10:   page_d = 1'b1;
                2'b11:   page_d = page_q;
                default: begin
                    if (fcnt_q == FCNT_LAST) begin
                        fcnt_d = '0;
                        page_d = ~page_q;
                    end else begin
                        fcnt_d = fcnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign page_word = page_q ? shadow_q[31:16] : shadow_q[15:0];
    assign nib       = page_word[{dig_q, 2'b00} +: 4];
    assign dp_n      = ~(page_q && (dig_q == 2'd3));

`ifdef DISP_LZ_BLANK_EN
    // A digit is suppressed when it and every more significant nibble is zero; digit 0 never is.
    logic [3:0] upper_zero;
    assign upper_zero[3] = (page_word[15:12] == 4'h0);
    assign upper_zero[2] = (page_word[15:8] == 8'h00);
    assign upper_zero[1] = (page_word[15:4] == 12'h000);
    assign upper_zero[0] = 1'b0;
    assign lz_blank      = upper_zero[dig_q];
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        phase  = (cnt_q < BLANK_END) ? PH_BLANK : PH_SHOW;
        led_d  = 8'hFF;
        sele_d = 4'hF;
        if (phase == PH_SHOW) begin
            sele_d = ~(4'b0001 << dig_q);
            led_d  = lz_blank ? {dp_n, 7'h7F} : {dp_n, seg7(nib)};
        end
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dig_q    <= 2'd0;
            fcnt_q   <= 16'd0;
            page_q   <= 1'b0;
            shadow_q <= 32'd0;
            led_q    <= 8'hFF;
            sele_q   <= 4'hF;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            fcnt_q   <= fcnt_d;
            page_q   <= page_d;
            shadow_q <= shadow_d;
            led_q    <= led_d;
            sele_q   <= sele_d;
            tick_q   <= tick_d;
        end
    end

    assign led        = led_q;
    assign sele       = sele_q;
    assign page       = page_q;
    assign frame_tick = tick_q;

endmodule
